// File: rtl/fp_mul_pkg.sv
// Shared types and width-parametric field helpers for the multicycle FP multiplier.
package fp_mul_pkg;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
  } flags_t;

  // Fields are passed zero-extended to MAX_W so one function serves any format.
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] fld_t;

  function automatic fld_t qnan(input int ew, input int mw);
    return ((fld_t'(1) << (ew + 1)) - fld_t'(1)) << (mw - 1);
  endfunction

  function automatic logic is_nan(input fld_t e, input fld_t f, input int ew);
    return (e == ((fld_t'(1) << ew) - fld_t'(1))) && (f != '0);
  endfunction

  function automatic logic is_inf(input fld_t e, input fld_t f, input int ew);
    return (e == ((fld_t'(1) << ew) - fld_t'(1))) && (f == '0);
  endfunction

  function automatic logic is_zero(input fld_t e);
    return e == '0;
  endfunction
endpackage

// File: rtl/fp_mul_seq_round_norm.sv
// Combinational normalise / round / range-clamp stage for the raw significand product.
module fp_round_norm
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W  = 1 + EXP_W + MAN_W,
  localparam int SW = MAN_W + 1
) (
  input  logic [2*SW-1:0] i_prod,
  input  logic            i_sign,
  input  logic [EXP_W-1:0] i_e1,
  input  logic [EXP_W-1:0] i_e2,
  input  logic            i_rne,
  output logic [W-1:0]    o_res,
  output flags_t          o_flags
);
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

  logic                  w_msb, w_guard, w_sticky, w_inc;
  logic [2*SW-1:0]       w_sh;
  logic [MAN_W-1:0]      w_frac;
  logic [MAN_W:0]        w_frac_r;
  logic signed [EW2-1:0] w_exp, w_exp_r;

  always_comb begin
    w_msb    = i_prod[2*SW-1];
    // Align so the leading one always sits at the top bit.
    w_sh     = w_msb ? i_prod : i_prod << 1;
    w_frac   = w_sh[2*SW-2:SW];
    w_guard  = w_sh[SW-1];
    w_sticky = |w_sh[SW-2:0];
    w_exp    = $signed({2'b00, i_e1}) + $signed({2'b00, i_e2}) - BIAS
             + $signed({{(EW2-1){1'b0}}, w_msb});
    w_inc    = i_rne & w_guard & (w_sticky | w_frac[0]);
    w_frac_r = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
    // A rounding carry leaves the fraction at zero; only the exponent moves.
    w_exp_r  = w_exp + $signed({{(EW2-1){1'b0}}, w_frac_r[MAN_W]});
    o_flags  = '0;
    if (w_exp_r >= EMAX) begin
      o_res            = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags.overflow = 1'b1;
    end else if (w_exp_r[EW2-1] || (w_exp_r == '0)) begin
      o_res             = {i_sign, {(W-1){1'b0}}};
      o_flags.underflow = 1'b1;
    end else begin
      o_res = {i_sign, w_exp_r[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
    end
  end
endmodule

// File: rtl/fp_mul_seq.sv
// Multicycle FP multiplier: shift-add significand product, then one normalise/round cycle.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] inp1,
  input  logic [W-1:0] inp2,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid
);
  localparam int SW = MAN_W + 1;
  localparam int CW = $clog2(MAN_W + 1);

  state_t          r_state;
  logic [W-1:0]    r_a, r_b, r_out;
  logic            r_rne, r_out_valid, r_in_ready;
  logic [2*SW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  flags_t          r_flags;

  logic [SW-1:0]      w_sa, w_sb;
  logic [2*SW-1:0]    w_addend;
  logic [EXP_W-1:0]   w_e1, w_e2;
  logic               w_sign, w_nan1, w_nan2, w_inf1, w_inf2, w_z1, w_z2;
  logic [W-1:0]       w_rn_res, w_res;
  flags_t             w_rn_flags, w_flags;

  assign w_e1     = r_a[W-2:MAN_W];
  assign w_e2     = r_b[W-2:MAN_W];
  assign w_sa     = {1'b1, r_a[MAN_W-1:0]};
  assign w_sb     = {1'b1, r_b[MAN_W-1:0]};
  assign w_sign   = r_a[W-1] ^ r_b[W-1];
  assign w_addend = w_sb[r_cnt] ? ({{SW{1'b0}}, w_sa} << r_cnt) : '0;

  assign w_nan1 = is_nan(fld_t'(w_e1), fld_t'(r_a[MAN_W-1:0]), EXP_W);
  assign w_nan2 = is_nan(fld_t'(w_e2), fld_t'(r_b[MAN_W-1:0]), EXP_W);
  assign w_inf1 = is_inf(fld_t'(w_e1), fld_t'(r_a[MAN_W-1:0]), EXP_W);
  assign w_inf2 = is_inf(fld_t'(w_e2), fld_t'(r_b[MAN_W-1:0]), EXP_W);
  assign w_z1   = is_zero(fld_t'(w_e1));
  assign w_z2   = is_zero(fld_t'(w_e2));

  fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rn (
    .i_prod  (r_acc),
    .i_sign  (w_sign),
    .i_e1    (w_e1),
    .i_e2    (w_e2),
    .i_rne   (r_rne),
    .o_res   (w_rn_res),
    .o_flags (w_rn_flags)
  );

  // Special operands override the arithmetic path; denormal exponents count as zero.
  always_comb begin
    w_res   = w_rn_res;
    w_flags = w_rn_flags;
    if (w_nan1 | w_nan2) begin
      w_res   = W'(qnan(EXP_W, MAN_W));
      w_flags = '0;
    end else if ((w_inf1 & w_z2) | (w_inf2 & w_z1)) begin
      w_res         = W'(qnan(EXP_W, MAN_W));
      w_flags       = '0;
      w_flags.invalid = 1'b1;
    end else if (w_inf1 | w_inf2) begin
      w_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags = '0;
    end else if (w_z1 | w_z2) begin
      w_res   = {w_sign, {(W-1){1'b0}}};
      w_flags = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_rne       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a        <= inp1;
          r_b        <= inp2;
          r_rne      <= rnd_mode;
          r_acc      <= '0;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= S_MUL;
        end
        S_MUL: begin
          r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(MAN_W)) r_state <= S_NORM;
        end
        S_NORM: begin
          r_out       <= w_res;
          r_flags     <= w_flags;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign overflow  = r_flags.overflow;
  assign underflow = r_flags.underflow;
  assign invalid   = r_flags.invalid;
endmodule
